// File: rtl/sram_bist_ctrl.sv
// Write/read-back self-test controller for a single-port synchronous RAM.
// Fills every address with an address-derived pattern, reads it all back and tallies mismatches.
module sram_bist_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_invert,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic [ADDR_W:0]   o_err_cnt,
    output logic              o_ce,
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    input  logic [DATA_W-1:0] i_rdata
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] CNT_END   = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] DRAIN_END = RD_LAT[ADDR_W:0];

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t            r_state, w_state_next;
    logic [ADDR_W:0]   r_cnt, w_cnt_next, w_cnt_inc;
    logic              r_inv, w_inv, w_start_acc;
    logic              r_ce, r_wr, r_busy, r_done, r_pass;
    logic [ADDR_W-1:0] r_addr, r_fail_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W:0]   r_err_cnt, w_err_next;
    logic              w_ce_next, w_wr_next, w_busy_next, w_done_next;
    logic [ADDR_W-1:0] w_addr_next;
    logic [DATA_W-1:0] w_wdata_next;
    logic              w_mis;

    // Compare pipeline: one stage per cycle of RAM read latency
    logic              r_pv [RD_LAT];
    logic [ADDR_W-1:0] r_pa [RD_LAT];
    logic [DATA_W-1:0] r_pp [RD_LAT];

    // (k+1) mod 2**DATA_W; truncating k first gives the same residue
    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] k, input logic inv);
        logic [DATA_W-1:0] s;
        s = DATA_W'(k) + DATA_W'(1);
        return s ^ {DATA_W{inv}};
    endfunction

    assign w_start_acc = (r_state == S_IDLE) && i_start;
    assign w_inv       = w_start_acc ? i_invert : r_inv;
    assign w_cnt_inc   = r_cnt + (ADDR_W+1)'(1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_WRITE;
                    w_cnt_next   = '0;
                end
            end
            S_WRITE: begin
                w_cnt_next = w_cnt_inc;
                if (w_cnt_inc == CNT_END) begin
                    w_state_next = S_READ;
                    w_cnt_next   = '0;
                end
            end
            S_READ: begin
                w_cnt_next = w_cnt_inc;
                if (w_cnt_inc == CNT_END) begin
                    w_state_next = S_DRAIN;
                    w_cnt_next   = '0;
                end
            end
            S_DRAIN: begin
                w_cnt_next = w_cnt_inc;
                if (w_cnt_inc == DRAIN_END) begin
                    w_state_next = S_DONE;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered, so they are derived from the next state
    always_comb begin
        w_ce_next    = (w_state_next == S_WRITE) || (w_state_next == S_READ);
        w_wr_next    = (w_state_next == S_WRITE);
        w_busy_next  = w_ce_next || (w_state_next == S_DRAIN);
        w_done_next  = (w_state_next == S_DONE);
        w_addr_next  = w_ce_next ? w_cnt_next[ADDR_W-1:0] : r_addr;
        w_wdata_next = w_wr_next ? pat(w_cnt_next[ADDR_W-1:0], w_inv) : r_wdata;
    end

    assign w_mis = r_pv[RD_LAT-1] && (i_rdata != r_pp[RD_LAT-1]);

    always_comb begin
        w_err_next = r_err_cnt;
        if (w_start_acc)
            w_err_next = '0;
        else if (w_mis)
            w_err_next = r_err_cnt + (ADDR_W+1)'(1);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ce        <= 1'b0;
            r_wr        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_inv       <= 1'b0;
            r_err_cnt   <= '0;
            r_fail_addr <= '0;
            r_pass      <= 1'b0;
        end else begin
            r_ce      <= w_ce_next;
            r_wr      <= w_wr_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_addr    <= w_addr_next;
            r_wdata   <= w_wdata_next;
            r_inv     <= w_inv;
            r_err_cnt <= w_err_next;
            if (w_start_acc)
                r_fail_addr <= '0;
            else if (w_mis && (r_err_cnt == '0))
                r_fail_addr <= r_pa[RD_LAT-1];
            if (w_start_acc)
                r_pass <= 1'b0;
            else if (w_done_next)
                r_pass <= (w_err_next == '0);
        end
    end

    // A read visible on the RAM port this cycle enters stage 0 at the edge
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_pv[k] <= 1'b0;
                r_pa[k] <= '0;
                r_pp[k] <= '0;
            end
        end else begin
            r_pv[0] <= r_ce && !r_wr;
            r_pa[0] <= r_addr;
            r_pp[0] <= pat(r_addr, r_inv);
            for (int k = 1; k < RD_LAT; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pa[k] <= r_pa[k-1];
                r_pp[k] <= r_pp[k-1];
            end
        end
    end

    assign o_ce        = r_ce;
    assign o_wr        = r_wr;
    assign o_addr      = r_addr;
    assign o_wdata     = r_wdata;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_fail_addr = r_fail_addr;
    assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Bench for sram_bist_ctrl: two controllers (read latency 1 and 2) each driving a behavioural RAM,
// with a per-lane scoreboard monitor checking busy every cycle and results on every done pulse.
module tb_sram_bist_ctrl;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int D  = 64;

    typedef struct {
        int lane;
        int s;
        bit pass;
        int fa;
        int ec;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic inv;
    logic fault;
    logic mon_en;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    logic          start_a [2];
    logic          busy_a  [2];
    logic          done_a  [2];
    logic          pass_a  [2];
    logic          ce_a    [2];
    logic          wr_a    [2];
    logic [AW-1:0] fa_a    [2];
    logic [AW-1:0] addr_a  [2];
    logic [AW:0]   ec_a    [2];
    logic [DW-1:0] wdata_a [2];
    logic [DW-1:0] rdata_a [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_zero(input int ln, input string tag);
        chk({tag, "_ce"},    32'(ce_a[ln]),    0);
        chk({tag, "_wr"},    32'(wr_a[ln]),    0);
        chk({tag, "_addr"},  32'(addr_a[ln]),  0);
        chk({tag, "_wdata"}, 32'(wdata_a[ln]), 0);
        chk({tag, "_busy"},  32'(busy_a[ln]),  0);
        chk({tag, "_done"},  32'(done_a[ln]),  0);
        chk({tag, "_pass"},  32'(pass_a[ln]),  0);
        chk({tag, "_fa"},    32'(fa_a[ln]),    0);
        chk({tag, "_ec"},    32'(ec_a[ln]),    0);
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            localparam int LAT = gi + 1;
            logic [DW-1:0] mem   [D];
            logic [DW-1:0] rpipe [LAT];

            sram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) u_dut (
                .i_clk       (clk),
                .i_reset     (rst),
                .i_start     (start_a[gi]),
                .i_invert    (inv),
                .o_busy      (busy_a[gi]),
                .o_done      (done_a[gi]),
                .o_pass      (pass_a[gi]),
                .o_fail_addr (fa_a[gi]),
                .o_err_cnt   (ec_a[gi]),
                .o_ce        (ce_a[gi]),
                .o_wr        (wr_a[gi]),
                .o_addr      (addr_a[gi]),
                .o_wdata     (wdata_a[gi]),
                .i_rdata     (rdata_a[gi])
            );

            // Behavioural RAM; the fault stores bit 0 stuck at 0 at addresses 4 and 40
            always @(posedge clk) begin
                if (ce_a[gi] && wr_a[gi])
                    mem[addr_a[gi]] <= (fault && (addr_a[gi] == 6'd4 || addr_a[gi] == 6'd40))
                                       ? (wdata_a[gi] & 8'hFE) : wdata_a[gi];
                if (ce_a[gi] && !wr_a[gi])
                    rpipe[0] <= mem[addr_a[gi]];
                for (int k = 1; k < LAT; k++)
                    rpipe[k] <= rpipe[k-1];
            end
            assign rdata_a[gi] = rpipe[LAT-1];

            always @(negedge clk) begin
                int   idx;
                int   dc;
                logic eb;
                if (mon_en && !rst) begin
                    idx = -1;
                    dc  = 0;
                    eb  = 1'b0;
                    foreach (exp_q[i])
                        if (idx < 0 && exp_q[i].lane == gi) idx = i;
                    if (idx >= 0) begin
                        dc = exp_q[idx].s + 2*D + LAT + 1;
                        eb = (cyc > exp_q[idx].s) && (cyc < dc);
                    end
                    chk($sformatf("busy_l%0d", gi), 32'(busy_a[gi]), 32'(eb));
                    if (done_a[gi]) begin
                        if (idx < 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL done_unexpected lane=%0d cyc=%0d actual=1 required=0", gi, cyc);
                        end else begin
                            $display("run lane=%0d start=%0d done_cyc=%0d pass=%0d fail_addr=%0d err_cnt=%0d",
                                     gi, exp_q[idx].s, cyc, pass_a[gi], fa_a[gi], ec_a[gi]);
                            chk($sformatf("done_cyc_l%0d", gi), cyc, dc);
                            chk($sformatf("pass_l%0d", gi), 32'(pass_a[gi]), 32'(exp_q[idx].pass));
                            chk($sformatf("fail_addr_l%0d", gi), 32'(fa_a[gi]), exp_q[idx].fa);
                            chk($sformatf("err_cnt_l%0d", gi), 32'(ec_a[gi]), exp_q[idx].ec);
                            exp_q.delete(idx);
                        end
                    end else if (idx >= 0 && cyc > dc) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL done_timeout lane=%0d cyc=%0d actual=none required=%0d", gi, cyc, dc);
                        exp_q.delete(idx);
                    end
                end
            end
        end
    endgenerate

    // One complete run on a lane; checks the first and last write data on the port
    task automatic run(input int ln, input bit iv, input bit ep, input int efa, input int eec,
                       input int w0, input int wl);
        int s;
        @(posedge clk); #1;
        inv = iv;
        start_a[ln] = 1'b1;
        s = cyc;
        exp_q.push_back('{ln, s, ep, efa, eec});
        @(posedge clk); #1;
        start_a[ln] = 1'b0;
        inv = ~iv;
        chk("addr_first", 32'(addr_a[ln]), 0);
        chk("wdata_first", 32'(wdata_a[ln]), w0);
        repeat (D-1) @(posedge clk);
        #1;
        chk("addr_last", 32'(addr_a[ln]), D-1);
        chk("wdata_last", 32'(wdata_a[ln]), wl);
        repeat (D+ln+3) @(posedge clk);
    endtask

    initial begin
        int s;
        rst = 1'b1;
        inv = 1'b0;
        fault = 1'b0;
        mon_en = 1'b0;
        start_a[0] = 1'b0;
        start_a[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero(0, "reset_l0");
        chk_zero(1, "reset_l1");
        rst = 1'b0;
        mon_en = 1'b1;

        run(0, 1'b0, 1'b1, 0, 0, 8'h01, 8'h40);
        run(0, 1'b1, 1'b1, 0, 0, 8'hFE, 8'hBF);

        fault = 1'b1;
        run(0, 1'b0, 1'b0, 4, 2, 8'h01, 8'h40);
        repeat (10) @(posedge clk);
        #1;
        chk("held_pass", 32'(pass_a[0]), 0);
        chk("held_fail_addr", 32'(fa_a[0]), 4);
        chk("held_err_cnt", 32'(ec_a[0]), 2);
        fault = 1'b0;

        // Start held high: back-to-back runs every 131 cycles
        @(posedge clk); #1;
        inv = 1'b0;
        start_a[0] = 1'b1;
        s = cyc;
        for (int k = 0; k < 3; k++)
            exp_q.push_back('{0, s + 131*k, 1'b1, 0, 0});
        while (cyc < s + 300) @(posedge clk);
        #1;
        start_a[0] = 1'b0;
        repeat (110) @(posedge clk);

        // Reset pulsed while writing address 20
        @(posedge clk); #1;
        inv = 1'b0;
        start_a[0] = 1'b1;
        s = cyc;
        exp_q.push_back('{0, s, 1'b1, 0, 0});
        @(posedge clk); #1;
        start_a[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("addr_pre_reset", 32'(addr_a[0]), 20);
        chk("wr_pre_reset", 32'(wr_a[0]), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_zero(0, "mid_reset");
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (200) @(posedge clk);

        run(0, 1'b0, 1'b1, 0, 0, 8'h01, 8'h40);
        run(1, 1'b0, 1'b1, 0, 0, 8'h01, 8'h40);

        repeat (5) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_bist_ctrl.md
# sram_bist_ctrl

Built-in self-test initiator for the single-port synchronous RAM (SingleRAM). It owns the RAM's ce/wr/addr/data port. On `i_start` it fills every address with a deterministic pattern, reads every address back, and compares the returned data against the expected pattern. It then reports pass/fail, the first failing address and the error count. It sits between the top-level test/control logic and the RAM instance.

## Interface
- `ADDR_W`, 6, RAM address width; depth `DEPTH = 2**ADDR_W`
- `DATA_W`, 8, RAM data width
- `RD_LAT`, 1, RAM read latency in cycles, legal 1..3
- `i_clk`  in  1  clock; all logic on rising edge
- `i_reset`  in  1  reset, asynchronous, active-high; single clock domain (`i_clk`)
- `i_start`  in  1  start request; sampled only in IDLE
- `i_invert`  in  1  pattern polarity; sampled together with `i_start`
- `o_busy`  out  1  test in progress
- `o_done`  out  1  one-cycle pulse when results are final
- `o_pass`  out  1  1 = zero mismatches; valid from `o_done`, held until next start
- `o_fail_addr`  out  ADDR_W  address of first mismatch; 0 if none
- `o_err_cnt`  out  ADDR_W+1  number of mismatching addresses (0..DEPTH)
- `o_ce`  out  1  RAM chip enable
- `o_wr`  out  1  RAM write enable (1 = write, 0 = read)
- `o_addr`  out  ADDR_W  RAM address
- `o_wdata`  out  DATA_W  RAM write data
- `i_rdata`  in  DATA_W  RAM read data

## Operation
- Pattern: `pat(k) = ((k+1) mod 2**DATA_W) ^ {DATA_W{inv}}`. Here `k` is the address, zero-extended, and `inv` is `i_invert` latched at start.
- FSM states and transitions:
  - IDLE: wait for `i_start`.
  - WRITE: issue write to addr 0..DEPTH-1, one per cycle, with `o_wdata = pat(addr)`.
  - READ: issue read to addr 0..DEPTH-1, one per cycle, with `o_wr = 0`.
  - DRAIN: RD_LAT cycles with `o_ce = 0`, waiting for the last returns.
  - DONE: 1 cycle, then back to IDLE.
- Address counter runs ADDR_W+1 bits wide. A phase ends when the counter reaches DEPTH; there is no wrap-around.
- Compare pipeline: each read issue pushes (valid, addr, `pat(addr)`) into an RD_LAT-deep shift register. When the valid bit emerges, `i_rdata` is compared in that cycle.
- On a mismatch:
  - `o_err_cnt` increments.
  - If this is the first mismatch, `o_fail_addr` captures the address.
- `o_pass = (o_err_cnt == 0)`; it is updated in the DONE cycle.
- Start handling:
  - Accepting a start clears `o_err_cnt`, `o_fail_addr` and `o_pass` to 0.
  - `i_start` in any state other than IDLE is ignored, including in the DONE cycle.

## Timing
- Reset (asynchronous):
  - All outputs go to 0 immediately: `o_ce`, `o_wr`, `o_addr`, `o_wdata`, `o_busy`, `o_done`, `o_pass`, `o_fail_addr`, `o_err_cnt`.
  - FSM goes to IDLE and the compare pipeline valids clear.
  - Reset mid-test aborts with no `o_done`.
- Cycle numbering: `i_start` is seen high in IDLE at cycle 0.
  - Cycles 1..DEPTH: WRITE. `o_ce = 1`, `o_wr = 1`, `o_addr = c-1`.
  - Cycles DEPTH+1..2·DEPTH: READ. `o_ce = 1`, `o_wr = 0`, `o_addr = c-DEPTH-1`.
  - Cycles 2·DEPTH+1..2·DEPTH+RD_LAT: DRAIN.
  - Cycle 2·DEPTH+RD_LAT+1: DONE. `o_done = 1`, `o_busy = 0`, and result outputs are final.
- `o_busy` is high in cycles 1..2·DEPTH+RD_LAT.
- RAM outputs are registered.
- Outside WRITE/READ: `o_ce = 0`, `o_wr = 0`. `o_addr` and `o_wdata` hold their last value.
- Read data for an issue in cycle c is compared in cycle c+RD_LAT. The last compare lands in the final DRAIN cycle.
- The earliest next start is accepted in the cycle after DONE.

## Test plan
- Fault-free behavioural RAM (RD_LAT = 1), `i_invert = 0`, start:
  - Writes 0x01 at addr 0 through 0x40 at addr 63, then 64 reads.
  - `o_done` at cycle 130; `o_pass = 1`, `o_err_cnt = 0`, `o_fail_addr = 0`; `o_busy` high cycles 1..129.
- `i_invert = 1`, start:
  - Writes 0xFE at addr 0 through 0xBF at addr 63.
  - `o_pass = 1`, `o_done` at cycle 130.
- Fault injection, RAM bit 0 stuck-at-0 at addr 4 and addr 40 (patterns 0x05, 0x29):
  - `o_pass = 0`, `o_fail_addr = 4`, `o_err_cnt = 2`.
  - Results held until the next start.
- `i_start` held high continuously:
  - Exactly one `o_done` per 131-cycle run (130 busy/done cycles plus 1 IDLE accept cycle).
  - No start is accepted in the DONE cycle.
- `i_reset` pulsed mid-write at addr 20:
  - All outputs are 0 in the same cycle and no `o_done` occurs.
  - The following start runs a full clean test with `o_pass = 1`.
- RD_LAT = 2 build with a 2-cycle RAM model: `o_done` at cycle 131, `o_pass = 1`.
